// File: rtl/func_reg_pkg.sv
// Shared definitions for the function-select register bank.
//   FS_*     : 3-bit FunSel encodings applied to one register per command
//   ST_*     : sequencer state encodings (idle vs. multi-cycle byte shift)
package func_reg_pkg;

  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_LD8    = 3'b100;
  localparam logic [2:0] FS_LD16   = 3'b101;
  localparam logic [2:0] FS_SHL8   = 3'b110;
  localparam logic [2:0] FS_SEXT16 = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/func_reg_alu.sv
// Combinational next-value logic for one register of the bank.
// Ports:
//   q          current register value
//   i          data operand
//   fun_sel    function select (FS_* encodings)
//   shift_byte byte shifted into the LSB for FS_SHL8
//   q_next     value to write back
//   wrap_set   inc/dec wrapped around
//   wrap_clr   function clears the sticky wrap flag
module func_reg_alu
  import func_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] i,
  input  logic [2:0]       fun_sel,
  input  logic [7:0]       shift_byte,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_set,
  output logic             wrap_clr
);

  always_comb begin
    q_next   = q;
    wrap_set = 1'b0;
    wrap_clr = 1'b0;
    case (fun_sel)
      FS_DEC: begin
        q_next   = q - WIDTH'(1);
        wrap_set = (q == '0);
      end
      FS_INC: begin
        q_next   = q + WIDTH'(1);
        wrap_set = &q;
      end
      FS_LOAD: begin
        q_next   = i;
        wrap_clr = 1'b1;
      end
      FS_CLR: begin
        q_next   = '0;
        wrap_clr = 1'b1;
      end
      FS_LD8: begin
        q_next      = '0;
        q_next[7:0] = i[7:0];
        wrap_clr    = 1'b1;
      end
      FS_LD16: begin
        q_next       = '0;
        q_next[15:0] = i[15:0];
        wrap_clr     = 1'b1;
      end
      FS_SHL8: begin
        q_next = {q[WIDTH-9:0], shift_byte};
      end
      FS_SEXT16: begin
        q_next       = {WIDTH{i[15]}};
        q_next[15:0] = i[15:0];
        wrap_clr     = 1'b1;
      end
      default: begin
        q_next = q;
      end
    endcase
  end

endmodule

// File: rtl/func_reg_bank.sv
// General register file of NUM_REGS function-select registers.
// Ports:
//   Clock, Reset_n         rising-edge clock, async active-low reset
//   CmdValid/CmdReady      command handshake; CmdReady low while shifting
//   CmdAddr, FunSel, I     target register, function, data operand
//   ShiftBytes             byte count for FS_SHL8 (0 acts as 1, clipped to WIDTH/8)
//   RdAddrA/B, QA/QB       two combinational read ports (0 for out-of-range)
//   ZeroVec, WrapVec       per-register zero status and sticky wrap flags
//   Done                   one-cycle pulse after the last update of a command
module func_reg_bank
  import func_reg_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NB_W     = $clog2(WIDTH / 8) + 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                CmdValid,
  output logic                CmdReady,
  input  logic [ADDR_W-1:0]   CmdAddr,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [NB_W-1:0]     ShiftBytes,
  input  logic [ADDR_W-1:0]   RdAddrA,
  input  logic [ADDR_W-1:0]   RdAddrB,
  output logic [WIDTH-1:0]    QA,
  output logic [WIDTH-1:0]    QB,
  output logic [NUM_REGS-1:0] ZeroVec,
  output logic [NUM_REGS-1:0] WrapVec,
  output logic                Done
);

  localparam int unsigned NumBytes = WIDTH / 8;

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wrap_q;
  logic                done_q, done_d;
  logic [0:0]          state_q, state_d;
  logic [WIDTH-1:0]    lat_i_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [NB_W-1:0]     idx_q, last_q;

  logic                accept, in_shift, wr_en, wr_ok;
  logic [NB_W-1:0]     n_bytes;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2:0]          wr_op;
  logic [WIDTH-1:0]    shifted, cur_q, alu_q;
  logic [7:0]          sh_byte;
  logic                wrap_set, wrap_clr;

  assign in_shift = (state_q == ST_SHIFT);
  assign CmdReady = (state_q == ST_IDLE);
  assign accept   = CmdValid && CmdReady;

  always_comb begin
    if (ShiftBytes == '0) begin
      n_bytes = NB_W'(1);
    end else if (32'(ShiftBytes) > NumBytes) begin
      n_bytes = NB_W'(NumBytes);
    end else begin
      n_bytes = ShiftBytes;
    end
  end

  // During SHIFT the write path replays the latched command one byte at a time.
  assign wr_addr = in_shift ? lat_addr_q : CmdAddr;
  assign wr_op   = in_shift ? FS_SHL8 : FunSel;
  assign shifted = lat_i_q >> {idx_q, 3'b000};
  assign sh_byte = in_shift ? shifted[7:0] : I[7:0];
  assign wr_en   = accept || in_shift;
  assign wr_ok   = 32'(wr_addr) < NUM_REGS;
  assign cur_q   = wr_ok ? regs_q[wr_addr] : '0;

  func_reg_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .q          (cur_q),
    .i          (I),
    .fun_sel    (wr_op),
    .shift_byte (sh_byte),
    .q_next     (alu_q),
    .wrap_set   (wrap_set),
    .wrap_clr   (wrap_clr)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (accept) begin
      if (FunSel == FS_SHL8 && n_bytes > NB_W'(1)) begin
        state_d = ST_SHIFT;
      end else begin
        done_d = 1'b1;
      end
    end else if (in_shift && idx_q == last_q) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      lat_i_q    <= '0;
      lat_addr_q <= '0;
      idx_q      <= '0;
      last_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        lat_i_q    <= I;
        lat_addr_q <= CmdAddr;
        idx_q      <= NB_W'(1);
        last_q     <= n_bytes - NB_W'(1);
      end else if (in_shift) begin
        idx_q <= idx_q + NB_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      wrap_q <= '0;
    end else if (wr_en && wr_ok) begin
      regs_q[wr_addr] <= alu_q;
      if (wrap_set) begin
        wrap_q[wr_addr] <= 1'b1;
      end else if (wrap_clr) begin
        wrap_q[wr_addr] <= 1'b0;
      end
    end
  end

  assign QA      = (32'(RdAddrA) < NUM_REGS) ? regs_q[RdAddrA] : '0;
  assign QB      = (32'(RdAddrB) < NUM_REGS) ? regs_q[RdAddrB] : '0;
  assign WrapVec = wrap_q;
  assign Done    = done_q;

  always_comb begin
    ZeroVec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      ZeroVec[r] = (regs_q[r] == '0);
    end
  end

endmodule
